// File: rtl/a09_pkg.sv
// Shared definitions for the register store sequencer: state encoding, bus widths and mode values.
package a09_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int BYTE_WIDTH = 8;
   localparam int DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BYTE0 = 2'd1,
      ST_BYTE1 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic MODE_STORE = 1'b0;
   localparam logic MODE_PUSH  = 1'b1;

endpackage

// File: rtl/reg_store_addr_gen.sv
// Registered byte address generator: base +0/+1 for stores, -1/-2 for pre-decrement pushes.
module reg_store_addr_gen
   import a09_pkg::*;
#(
   parameter int AddrWidth = ADDR_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  state_t               state_i,
   input  logic                 push_i,
   input  logic [AddrWidth-1:0] base_i,
   output logic [AddrWidth-1:0] addr_o
);

   logic [AddrWidth-1:0] offset;

   // Offsets are two's complement so the add wraps modulo 2^AddrWidth.
   always_comb begin
      offset = '0;
      case (state_i)
         ST_BYTE0: offset = (push_i == MODE_PUSH) ? '1 : '0;
         ST_BYTE1: offset = (push_i == MODE_PUSH) ? ~AddrWidth'(1) : AddrWidth'(1);
         default:  offset = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         addr_o <= '0;
      end else if (state_i == ST_BYTE0 || state_i == ST_BYTE1) begin
         addr_o <= base_i + offset;
      end
   end

endmodule

// File: rtl/reg_store_seq.sv
// Serialises a 16-bit register onto the 8-bit write bus as two byte writes, big-endian,
// for plain stores and pre-decrement stack pushes.
//
// state    | meaning
// ST_IDLE  | waiting for start_ni low; last bus values held
// ST_BYTE0 | first byte write (store: high byte, push: low byte)
// ST_BYTE1 | second byte write (store: low byte, push: high byte)
// ST_DONE  | one-cycle done pulse, sp_o valid
module reg_store_seq
   import a09_pkg::*;
#(
   parameter int DataWidth = DATA_WIDTH,
   parameter int AddrWidth = ADDR_WIDTH,
   parameter int ByteWidth = BYTE_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 start_ni,
   input  logic                 push_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] data_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [ByteWidth-1:0] mem_data_o,
   output logic                 mem_wr_no,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [AddrWidth-1:0] sp_o
);

   state_t               state_q, state_d;
   logic [DataWidth-1:0] data_q;
   logic [AddrWidth-1:0] addr_q;
   logic                 push_q;

   logic                 accept;
   logic [DataWidth-1:0] data_src;
   logic [AddrWidth-1:0] addr_src;
   logic                 push_src;

   logic                 wr_n_d, busy_d, done_d;
   logic [ByteWidth-1:0] data_d;
   logic [AddrWidth-1:0] sp_d;

   // On the accepting edge the capture registers are not loaded yet, so bypass them.
   assign accept   = (state_q == ST_IDLE) && !start_ni;
   assign data_src = accept ? data_i : data_q;
   assign addr_src = accept ? addr_i : addr_q;
   assign push_src = accept ? push_i : push_q;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         addr_q     <= '0;
         push_q     <= MODE_STORE;
         mem_wr_no  <= 1'b1;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         mem_data_o <= '0;
         sp_o       <= '0;
      end else begin
         state_q    <= state_d;
         mem_wr_no  <= wr_n_d;
         busy_o     <= busy_d;
         done_o     <= done_d;
         mem_data_o <= data_d;
         sp_o       <= sp_d;
         if (accept) begin
            data_q <= data_i;
            addr_q <= addr_i;
            push_q <= push_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = start_ni ? ST_IDLE : ST_BYTE0;
         ST_BYTE0: state_d = ST_BYTE1;
         ST_BYTE1: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      wr_n_d = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      data_d = mem_data_o;
      sp_d   = sp_o;
      case (state_d)
         ST_BYTE0: begin
            wr_n_d = 1'b0;
            busy_d = 1'b1;
            data_d = (push_src == MODE_PUSH) ? data_src[ByteWidth-1:0]
                                             : data_src[DataWidth-1 -: ByteWidth];
         end
         ST_BYTE1: begin
            wr_n_d = 1'b0;
            busy_d = 1'b1;
            data_d = (push_src == MODE_PUSH) ? data_src[DataWidth-1 -: ByteWidth]
                                             : data_src[ByteWidth-1:0];
         end
         ST_DONE: begin
            done_d = 1'b1;
            sp_d   = (push_src == MODE_PUSH) ? addr_src - AddrWidth'(2) : addr_src;
         end
         default: ;
      endcase
   end

   reg_store_addr_gen #(
      .AddrWidth(AddrWidth)
   ) u_addr_gen (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .state_i (state_d),
      .push_i  (push_src),
      .base_i  (addr_src),
      .addr_o  (mem_addr_o)
   );

endmodule

// File: tb/tb_reg_store_seq.sv
// Self-checking bench for reg_store_seq: directed scenarios plus random traffic against a
// transaction-level model that expands each accepted request into its two byte writes.
module tb_reg_store_seq;

   logic        Clock_TB = 1'b0;
   logic        reset_n  = 1'b0;
   logic        start_n  = 1'b1;
   logic        push     = 1'b0;
   logic [15:0] addr     = '0;
   logic [15:0] data     = '0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_wr_n;
   logic        busy;
   logic        done;
   logic [15:0] sp;

   always #5 Clock_TB = ~Clock_TB;

   reg_store_seq dut (
      .clk_i     (Clock_TB),
      .reset_ni  (reset_n),
      .start_ni  (start_n),
      .push_i    (push),
      .addr_i    (addr),
      .data_i    (data),
      .mem_addr_o(mem_addr),
      .mem_data_o(mem_data),
      .mem_wr_no (mem_wr_n),
      .busy_o    (busy),
      .done_o    (done),
      .sp_o      (sp)
   );

   int errors = 0;
   int checks = 0;

   // Model: cycles since acceptance (0 = free) and the write list of the current request.
   int          m_age;
   logic [15:0] m_wr_addr [2];
   logic [7:0]  m_wr_data [2];
   logic [15:0] m_sp;
   logic        e_wr_n, e_busy, e_done;
   logic [15:0] e_addr, e_sp;
   logic [7:0]  e_data;

   int strobes, dones, cycle, last_done_cycle, done_gap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   task automatic model_edge(input logic rn, input logic sn, input logic p,
                             input logic [15:0] a, input logic [15:0] d);
      logic [15:0] hi_addr;
      if (!rn) begin
         m_age = 0;
         e_addr = '0; e_data = '0; e_sp = '0;
      end else if (m_age == 0) begin
         if (!sn) begin
            // Big-endian: high byte at the lower address of the two.
            hi_addr = p ? a - 16'd2 : a;
            if (!p) begin
               m_wr_addr[0] = hi_addr;         m_wr_data[0] = d[15:8];
               m_wr_addr[1] = hi_addr + 16'd1; m_wr_data[1] = d[7:0];
            end else begin
               m_wr_addr[0] = hi_addr + 16'd1; m_wr_data[0] = d[7:0];
               m_wr_addr[1] = hi_addr;         m_wr_data[1] = d[15:8];
            end
            m_sp  = hi_addr + (p ? 16'd0 : 16'd0);
            m_sp  = p ? a - 16'd2 : a;
            m_age = 1;
         end
      end else if (m_age == 3) begin
         m_age = 0;
      end else begin
         m_age++;
      end
      e_wr_n = !(m_age == 1 || m_age == 2);
      e_busy = (m_age == 1 || m_age == 2);
      e_done = (m_age == 3);
      if (m_age == 1 || m_age == 2) begin
         e_addr = m_wr_addr[m_age-1];
         e_data = m_wr_data[m_age-1];
      end
      if (m_age == 3) e_sp = m_sp;
   endtask

   task automatic step(input logic rn, input logic sn, input logic p,
                       input logic [15:0] a, input logic [15:0] d);
      @(negedge Clock_TB);
      reset_n = rn; start_n = sn; push = p; addr = a; data = d;
      @(posedge Clock_TB);
      model_edge(rn, sn, p, a, d);
      #1;
      cycle++;
      check("wr_n", {31'd0, mem_wr_n}, {31'd0, e_wr_n});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("addr", {16'd0, mem_addr}, {16'd0, e_addr});
      check("data", {24'd0, mem_data}, {24'd0, e_data});
      check("sp", {16'd0, sp}, {16'd0, e_sp});
      if (mem_wr_n === 1'b0) strobes++;
      if (done === 1'b1) begin
         dones++;
         done_gap = cycle - last_done_cycle;
         last_done_cycle = cycle;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, $urandom_range(0, 1), 16'($urandom), 16'($urandom));
   endtask

   // One full transfer with constant expectations for each of its three busy/done cycles.
   task automatic xfer(input string tag, input logic p, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] a0, input logic [7:0] d0,
                       input logic [15:0] a1, input logic [7:0] d1, input logic [15:0] spx);
      step(1'b1, 1'b0, p, a, d);
      check({tag, "_b0_addr"}, {16'd0, mem_addr}, {16'd0, a0});
      check({tag, "_b0_data"}, {24'd0, mem_data}, {24'd0, d0});
      check({tag, "_b0_wr"}, {31'd0, mem_wr_n}, 32'd0);
      step(1'b1, 1'b1, ~p, 16'($urandom), 16'($urandom));
      check({tag, "_b1_addr"}, {16'd0, mem_addr}, {16'd0, a1});
      check({tag, "_b1_data"}, {24'd0, mem_data}, {24'd0, d1});
      step(1'b1, 1'b1, p, a, d);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_sp"}, {16'd0, sp}, {16'd0, spx});
      step(1'b1, 1'b1, p, a, d);
   endtask

   initial begin
      m_age = 0; cycle = 0; strobes = 0; dones = 0; last_done_cycle = 0; done_gap = 0;
      e_wr_n = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0; e_sp = '0;

      step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);
      check("rst_wr", {31'd0, mem_wr_n}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      idle(2);

      xfer("store",  1'b0, 16'h00A0, 16'h1234, 16'h00A0, 8'h12, 16'h00A1, 8'h34, 16'h00A0);
      xfer("push",   1'b1, 16'h0400, 16'hBEEF, 16'h03FF, 8'hEF, 16'h03FE, 8'hBE, 16'h03FE);
      xfer("st_wrap", 1'b0, 16'hFFFF, 16'hA55A, 16'hFFFF, 8'hA5, 16'h0000, 8'h5A, 16'hFFFF);
      xfer("ps_wrap1", 1'b1, 16'h0001, 16'hA55A, 16'h0000, 8'h5A, 16'hFFFF, 8'hA5, 16'hFFFF);
      xfer("ps_wrap0", 1'b1, 16'h0000, 16'hC33C, 16'hFFFF, 8'h3C, 16'hFFFE, 8'hC3, 16'hFFFE);

      // Captured values survive input changes; a start pulse during the transfer is ignored.
      strobes = 0; dones = 0;
      step(1'b1, 1'b0, 1'b0, 16'h0300, 16'h1234);
      step(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
      check("cap_b1_data", {24'd0, mem_data}, 32'h34);
      check("cap_b1_addr", {16'd0, mem_addr}, 32'h0301);
      idle(5);
      check("cap_strobes", strobes, 2);
      check("cap_dones", dones, 1);

      // Reset in the middle of a store: no more strobes and no done pulse.
      step(1'b1, 1'b0, 1'b0, 16'h0050, 16'h5678);
      strobes = 0; dones = 0;
      step(1'b0, 1'b1, 1'b0, 16'h0050, 16'h5678);
      check("abort_wr", {31'd0, mem_wr_n}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      idle(5);
      check("abort_strobes", strobes, 0);
      check("abort_dones", dones, 0);

      // Start held low for 8 edges: two transfers, done pulses 4 cycles apart.
      strobes = 0; dones = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i[0], 16'h2000 + 16'(i), 16'hF00D);
      idle(4);
      check("b2b_strobes", strobes, 4);
      check("b2b_dones", dones, 2);
      check("b2b_gap", done_gap, 4);

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom),
              16'($urandom));
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
